// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ITER = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply and restoring divide on
// operand magnitudes, with sign fix-up and a one-cycle done pulse for writeback.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  state_e          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] a_mag_q, a_mag_d;
  logic [XLEN-1:0] b_mag_q, b_mag_d;
  logic            neg_q, neg_d;
  logic            neg_rem_q, neg_rem_d;
  logic [63:0]     acc_q, acc_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            in_is_div, in_signed_a, in_signed_b, in_a_neg, in_b_neg;
  logic [XLEN-1:0] in_a_mag, in_b_mag;
  logic [32:0]     mul_sum;
  logic [63:0]     mul_step;
  logic [32:0]     div_diff;
  logic [63:0]     div_step;
  logic [63:0]     prod;
  logic [XLEN-1:0] quo, rem, final_val;

  // Operand decode at the accepting edge.
  always_comb begin
    in_is_div   = funct3[2];
    in_signed_a = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                  (funct3 == F3_DIV) || (funct3 == F3_REM);
    in_signed_b = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                  (funct3 == F3_DIV) || (funct3 == F3_REM);
    in_a_neg    = in_signed_a & op_a[XLEN-1];
    in_b_neg    = in_signed_b & op_b[XLEN-1];
    in_a_mag    = in_a_neg ? (~op_a + 32'd1) : op_a;
    in_b_mag    = in_b_neg ? (~op_b + 32'd1) : op_b;
  end

  // Multiply: acc holds {partial product, remaining multiplier bits}.
  // Divide: acc holds {partial remainder, dividend bits shifting into quotient bits}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_mag_q} : 33'd0);
    mul_step = {mul_sum, acc_q[31:1]};
    div_diff = acc_q[63:31] - {1'b0, b_mag_q};
    if (div_diff[32]) begin
      div_step = {acc_q[62:0], 1'b0};
    end else begin
      div_step = {div_diff[31:0], acc_q[30:0], 1'b1};
    end
  end

  always_comb begin
    prod = neg_q ? (~acc_q + 64'd1) : acc_q;
    quo  = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    unique case (f3_q)
      F3_MUL:                      final_val = prod[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_val = prod[63:32];
      F3_DIV, F3_DIVU:             final_val = quo;
      default:                     final_val = rem;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    result_d  = result_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          f3_d      = funct3;
          rd_d      = rd_in;
          a_mag_d   = in_a_mag;
          b_mag_d   = in_b_mag;
          neg_d     = in_a_neg ^ in_b_neg;
          neg_rem_d = in_a_neg;
          cnt_d     = '0;
          if (in_is_div && (op_b == '0)) begin
            // Divide by zero: preload {remainder, quotient} and skip the iterations.
            acc_d     = {op_a, 32'hFFFF_FFFF};
            neg_d     = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = StDone;
          end else if (in_is_div && !funct3[0] && (op_a == 32'h8000_0000) &&
                       (op_b == 32'hFFFF_FFFF)) begin
            acc_d     = {32'd0, 32'h8000_0000};
            neg_d     = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = StDone;
          end else begin
            acc_d   = {32'd0, in_is_div ? in_a_mag : in_b_mag};
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d = f3_q[2] ? div_step : mul_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(ITER - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        result_d = final_val;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
    end
  end

  // The final value is visible in the DONE cycle and held afterwards by result_q.
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = done ? final_val : result_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one op and waits for done; cycles counted from the start cycle (start cycle = 0).
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input int exp_lat);
    int cyc;
    start  = 1'b1;
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    rd_in  = rd;
    @(posedge clk);
    #1;
    start  = 1'b0;
    funct3 = 3'b000;
    op_a   = 32'h0;
    op_b   = 32'h0;
    rd_in  = 5'd0;
    cyc    = 1;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (cyc !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, exp_lat);
    end
    checks++;
    if (result !== exp) begin
      errors++;
      $display("FAIL %s result: got %h, expected %h", name, result, exp);
    end
    checks++;
    if (rd_out !== rd) begin
      errors++;
      $display("FAIL %s rd_out: got %0d, expected %0d", name, rd_out, rd);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== exp) begin
      errors++;
      $display("FAIL %s after done: done=%b busy=%b result=%h, expected 0 0 %h",
               name, done, busy, result, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    funct3 = 3'b000;
    op_a = 32'h0;
    op_b = 32'h0;
    rd_in = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || rd_out !== 5'd0) begin
      errors++;
      $display("FAIL reset state: busy=%b done=%b result=%h rd_out=%0d, expected all zero",
               busy, done, result, rd_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_multiply();
    run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, 33);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 33);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, 33);
  endtask

  task automatic test_divide();
    run_op("div",  3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7,  32'hFFFF_FFFD, 33);
    run_op("rem",  3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8,  32'hFFFF_FFFF, 33);
    run_op("divu", 3'b101, 32'd100,       32'd7, 5'd9,  32'd14,        33);
    run_op("remu", 3'b111, 32'd100,       32'd7, 5'd10, 32'd2,         33);
  endtask

  task automatic test_fast_path();
    run_op("div0",  3'b100, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 1);
    run_op("remu0", 3'b111, 32'd5,         32'd0,         5'd12, 32'd5,         1);
    run_op("divov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
    run_op("remov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         1);
  endtask

  task automatic test_reset_mid_calc();
    int seen_done;
    start  = 1'b1;
    funct3 = 3'b101;
    op_a   = 32'd1000;
    op_b   = 32'd3;
    rd_in  = 5'd20;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midcalc busy before reset: got %b, expected 1", busy);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || rd_out !== 5'd0) begin
      errors++;
      $display("FAIL midcalc after reset: busy=%b done=%b result=%h rd_out=%0d, expected 0",
               busy, done, result, rd_out);
    end
    seen_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      errors++;
      $display("FAIL midcalc aborted op: %0d active cycles, expected 0", seen_done);
    end
  endtask

  task automatic test_ignore_start();
    int cyc;
    int extra;
    start  = 1'b1;
    funct3 = 3'b011;
    op_a   = 32'h0001_0000;
    op_b   = 32'h0003_0000;
    rd_in  = 5'd21;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 100) begin
      if (cyc == 5) begin
        start  = 1'b1;
        funct3 = 3'b000;
        op_a   = 32'd9;
        op_b   = 32'd9;
        rd_in  = 5'd30;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (cyc !== 33 || result !== 32'h0000_0003 || rd_out !== 5'd21) begin
      errors++;
      $display("FAIL ignore calc start: cyc=%0d result=%h rd=%0d, expected 33 00000003 21",
               cyc, result, rd_out);
    end
    // Request in the DONE cycle must not be accepted.
    start  = 1'b1;
    funct3 = 3'b100;
    op_a   = 32'd5;
    op_b   = 32'd0;
    rd_in  = 5'd31;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || result !== 32'h0000_0003 || rd_out !== 5'd21) begin
      errors++;
      $display("FAIL ignore done start: busy=%b result=%h rd=%0d, expected 0 00000003 21",
               busy, result, rd_out);
    end
    extra = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignore done start activity: %0d active cycles, expected 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_mul", 3'b000, 32'h0001_0001, 32'h0001_0001, 5'd1, 32'h0002_0001, 33);
    run_op("b2b_div", 3'b100, 32'd100,       32'hFFFF_FFF9, 5'd2, 32'hFFFF_FFF2, 33);
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_fast_path();
    test_reset_mid_calc();
    test_ignore_start();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
